// File: rtl/program_sequencer_if.sv
// Control/status bundle between the control unit (master) and the program sequencer (slave).
// The control unit drives stall/branch/call/ret and their targets, and observes the fetch address and stack status.
interface program_sequencer_if #(
  parameter int ADDR_W = 6
);
  logic              stall;
  logic              branch;
  logic [ADDR_W-1:0] branch_addr;
  logic              call;
  logic [ADDR_W-1:0] call_addr;
  logic              ret;
  logic [ADDR_W-1:0] pc_out;
  logic              ras_empty;
  logic              ras_full;
  logic              ras_err;

  modport master (
    output stall, branch, branch_addr, call, call_addr, ret,
    input  pc_out, ras_empty, ras_full, ras_err
  );

  modport slave (
    input  stall, branch, branch_addr, call, call_addr, ret,
    output pc_out, ras_empty, ras_full, ras_err
  );
endinterface

// File: rtl/program_sequencer.sv
// Instruction-fetch address source with stall/branch/call/ret; 1-cycle latency, stall holds all state.
// Define PC_RAS_EN to build the return-address stack; otherwise call acts as branch and ret is ignored.
module program_sequencer #(
  parameter int                ADDR_W    = 6,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int                RAS_DEPTH = 4
) (
  input logic                clk,
  input logic                rst,
  program_sequencer_if.slave bus
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] pc_inc;

  assign pc_inc     = pc_q + 1'b1;
  assign bus.pc_out = pc_q;

`ifdef PC_RAS_EN
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam int IDX_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  logic [ADDR_W-1:0] stack [RAS_DEPTH];
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              err_q;
  logic              err_d;
  logic              push;
  logic              empty;
  logic              full;
  logic [IDX_W-1:0]  top_idx;
  logic [IDX_W-1:0]  push_idx;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CNT_W'(RAS_DEPTH));
  assign top_idx  = IDX_W'(cnt_q - CNT_W'(1));
  assign push_idx = IDX_W'(cnt_q);

  always_comb begin
    pc_d  = pc_q;
    cnt_d = cnt_q;
    err_d = err_q;
    push  = 1'b0;
    if (!bus.stall) begin
      if (bus.ret) begin
        if (!empty) begin
          pc_d  = stack[top_idx];
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          pc_d  = pc_inc;
          err_d = 1'b1;
        end
      end else if (bus.call) begin
        pc_d = bus.call_addr;
        // A call on a full stack still jumps; only the return address is lost.
        if (!full) begin
          push  = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          err_d = 1'b1;
        end
      end else if (bus.branch) begin
        pc_d = bus.branch_addr;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= RESET_VEC;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // Stack contents need no reset; the count alone defines validity.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      stack[push_idx] <= pc_inc;
    end
  end

  assign bus.ras_empty = empty;
  assign bus.ras_full  = full;
  assign bus.ras_err   = err_q;
`else
  logic unused_ret;

  assign unused_ret = bus.ret;

  always_comb begin
    pc_d = pc_q;
    if (!bus.stall) begin
      if (bus.call) begin
        pc_d = bus.call_addr;
      end else if (bus.branch) begin
        pc_d = bus.branch_addr;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_VEC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign bus.ras_empty = 1'b1;
  assign bus.ras_full  = 1'b0;
  assign bus.ras_err   = 1'b0;
`endif

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer (ADDR_W=6, RESET_VEC=5, RAS_DEPTH=4); status compared as {pc, empty, full, err}.
module tb_program_sequencer;
  localparam int ADDR_W = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passed = 0;
  logic [ADDR_W+2:0] obs;

  program_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  program_sequencer #(
    .ADDR_W   (ADDR_W),
    .RESET_VEC(6'd5),
    .RAS_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  assign obs = {bus.pc_out, bus.ras_empty, bus.ras_full, bus.ras_err};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.stall = 1'b0; bus.branch = 1'b0; bus.call = 1'b0; bus.ret = 1'b0;
    bus.branch_addr = '0; bus.call_addr = '0;
  endtask

  task automatic goto_pc(input logic [ADDR_W-1:0] a);
    bus.branch = 1'b1; bus.branch_addr = a;
    step();
    bus.branch = 1'b0;
  endtask

  task automatic do_call(input logic [ADDR_W-1:0] a);
    bus.call = 1'b1; bus.call_addr = a;
    step();
    bus.call = 1'b0;
  endtask

  task automatic do_ret();
    bus.ret = 1'b1;
    step();
    bus.ret = 1'b0;
  endtask

  task automatic test_reset();
    logic [ADDR_W+2:0] exp;
    idle_inputs();
    rst = 1'b1;
    step(); step();
    exp = {6'd5, 3'b100};
    checks++; if (obs !== exp) $display("FAIL reset_state got %h want %h", obs, exp); else passed++;
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      exp = {6'(5 + i), 3'b100};
      checks++; if (obs !== exp) $display("FAIL post_reset_inc%0d got %h want %h", i, obs, exp); else passed++;
    end
  endtask

  task automatic test_wrap();
    logic [ADDR_W+2:0] exp;
    goto_pc(6'd63);
    exp = {6'd63, 3'b100};
    checks++; if (obs !== exp) $display("FAIL branch_to_63 got %h want %h", obs, exp); else passed++;
    step();
    exp = {6'd0, 3'b100};
    checks++; if (obs !== exp) $display("FAIL wrap_to_0 got %h want %h", obs, exp); else passed++;
  endtask

  task automatic test_stall_plain();
    logic [ADDR_W+2:0] exp;
    goto_pc(6'd12);
    bus.stall = 1'b1; bus.branch = 1'b1; bus.branch_addr = 6'd33;
    step(); step();
    exp = {6'd12, 3'b100};
    checks++; if (obs !== exp) $display("FAIL stall_hold got %h want %h", obs, exp); else passed++;
    bus.stall = 1'b0;
    step();
    bus.branch = 1'b0;
    exp = {6'd33, 3'b100};
    checks++; if (obs !== exp) $display("FAIL branch_after_stall got %h want %h", obs, exp); else passed++;
  endtask

`ifdef PC_RAS_EN
  task automatic test_call_ret();
    logic [ADDR_W+2:0] exp;
    goto_pc(6'd10);
    do_call(6'd40);
    exp = {6'd40, 3'b000};
    checks++; if (obs !== exp) $display("FAIL call_target got %h want %h", obs, exp); else passed++;
    step(); step();
    exp = {6'd42, 3'b000};
    checks++; if (obs !== exp) $display("FAIL in_subroutine got %h want %h", obs, exp); else passed++;
    do_ret();
    exp = {6'd11, 3'b100};
    checks++; if (obs !== exp) $display("FAIL ret_addr got %h want %h", obs, exp); else passed++;
  endtask

  task automatic test_nested_overflow();
    logic [ADDR_W+2:0] exp;
    logic [ADDR_W-1:0] rets [4] = '{6'd42, 6'd32, 6'd22, 6'd2};
    goto_pc(6'd1);  do_call(6'd20);
    goto_pc(6'd21); do_call(6'd30);
    goto_pc(6'd31); do_call(6'd40);
    goto_pc(6'd41); do_call(6'd50);
    exp = {6'd50, 3'b010};
    checks++; if (obs !== exp) $display("FAIL stack_full got %h want %h", obs, exp); else passed++;
    do_call(6'd60);
    exp = {6'd60, 3'b011};
    checks++; if (obs !== exp) $display("FAIL overflow got %h want %h", obs, exp); else passed++;
    for (int i = 0; i < 4; i++) begin
      do_ret();
      exp = {rets[i], (i == 3), 1'b0, 1'b1};
      checks++; if (obs !== exp) $display("FAIL nested_ret%0d got %h want %h", i, obs, exp); else passed++;
    end
    do_ret();
    exp = {6'd3, 3'b101};
    checks++; if (obs !== exp) $display("FAIL underflow got %h want %h", obs, exp); else passed++;
  endtask

  task automatic test_stall_priority();
    logic [ADDR_W+2:0] exp;
    rst = 1'b1; step(); rst = 1'b0;
    goto_pc(6'd6);
    do_call(6'd12);
    bus.stall = 1'b1; bus.ret = 1'b1; bus.call = 1'b1; bus.call_addr = 6'd50;
    bus.branch = 1'b1; bus.branch_addr = 6'd55;
    for (int i = 0; i < 3; i++) begin
      step();
      exp = {6'd12, 3'b000};
      checks++; if (obs !== exp) $display("FAIL stall_all%0d got %h want %h", i, obs, exp); else passed++;
    end
    bus.stall = 1'b0;
    step();
    idle_inputs();
    exp = {6'd7, 3'b100};
    checks++; if (obs !== exp) $display("FAIL ret_priority got %h want %h", obs, exp); else passed++;
    bus.call = 1'b1; bus.call_addr = 6'd25; bus.branch = 1'b1; bus.branch_addr = 6'd44;
    step();
    idle_inputs();
    exp = {6'd25, 3'b000};
    checks++; if (obs !== exp) $display("FAIL call_over_branch got %h want %h", obs, exp); else passed++;
  endtask

  task automatic test_reset_mid_chain();
    logic [ADDR_W+2:0] exp;
    do_call(6'd30);
    rst = 1'b1; step(); rst = 1'b0;
    exp = {6'd5, 3'b100};
    checks++; if (obs !== exp) $display("FAIL reset_clears_stack got %h want %h", obs, exp); else passed++;
    do_ret();
    exp = {6'd6, 3'b101};
    checks++; if (obs !== exp) $display("FAIL ret_after_reset got %h want %h", obs, exp); else passed++;
  endtask
`else
  task automatic test_no_ras();
    logic [ADDR_W+2:0] exp;
    goto_pc(6'd3);
    do_call(6'd30);
    exp = {6'd30, 3'b100};
    checks++; if (obs !== exp) $display("FAIL call_as_branch got %h want %h", obs, exp); else passed++;
    do_ret();
    exp = {6'd31, 3'b100};
    checks++; if (obs !== exp) $display("FAIL ret_ignored got %h want %h", obs, exp); else passed++;
    bus.ret = 1'b1; bus.branch = 1'b1; bus.branch_addr = 6'd17;
    step();
    idle_inputs();
    exp = {6'd17, 3'b100};
    checks++; if (obs !== exp) $display("FAIL ret_branch got %h want %h", obs, exp); else passed++;
    bus.call = 1'b1; bus.call_addr = 6'd25; bus.branch = 1'b1; bus.branch_addr = 6'd44;
    step();
    idle_inputs();
    exp = {6'd25, 3'b100};
    checks++; if (obs !== exp) $display("FAIL call_over_branch got %h want %h", obs, exp); else passed++;
    for (int i = 0; i < 4; i++) do_ret();
    exp = {6'd29, 3'b100};
    checks++; if (obs !== exp) $display("FAIL ret_burst got %h want %h", obs, exp); else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_wrap();
    test_stall_plain();
`ifdef PC_RAS_EN
    test_call_ret();
    test_nested_overflow();
    test_stall_priority();
    test_reset_mid_chain();
`else
    test_no_ras();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/program_sequencer.md
# program_sequencer

Parametrised program sequencer that replaces the fixed 6-bit counter as the instruction-fetch address source. It holds the current fetch address, steps it each cycle, and supports stall, branch, call and return with an internal return-address stack (RAS). Its output drives the instruction ROM address directly; the control unit drives its control inputs.

## Interface
Parameters:
- ADDR_W, 6, width of the fetch address; addresses 2^ADDR_W ROM locations
- RESET_VEC, 0, value loaded into pc_out on reset; must fit in ADDR_W bits
- RAS_DEPTH, 4, number of return-address stack entries; at least 1

Ports:
- clk  in  1  clock; all state changes on its rising edge
- rst  in  1  reset; synchronous, active-high
- stall  in  1  hold pc_out and all stack state for this cycle
- branch  in  1  load branch_addr
- branch_addr  in  ADDR_W  branch target
- call  in  1  push return address, then load call_addr
- call_addr  in  ADDR_W  subroutine target
- ret  in  1  pop top of stack into pc_out
- pc_out  out  ADDR_W  current fetch address (registered)
- ras_empty  out  1  stack holds 0 entries (registered state)
- ras_full  out  1  stack holds RAS_DEPTH entries
- ras_err  out  1  sticky: overflow or underflow has occurred

## Operation
- Next-state priority, evaluated each rising edge: rst > stall > ret > call > branch > increment.
- rst: pc_out = RESET_VEC, stack count = 0, ras_err = 0. Stack contents don't-care.
- stall: pc_out, stack contents, stack count and ras_err are all held. Other inputs are ignored.
- ret, stack not empty: pc_out = top entry, count decrements.
- ret, stack empty (underflow): pc_out = pc_out + 1, ras_err set, count stays 0.
- call, stack not full: the return address pc_out + 1 (mod 2^ADDR_W) is pushed, count increments, pc_out = call_addr.
- call, stack full (overflow): pc_out = call_addr, the push is discarded, existing entries are unchanged, ras_err set.
- branch: pc_out = branch_addr; the stack is untouched.
- No control asserted: pc_out = pc_out + 1.
- Arithmetic is ADDR_W-bit unsigned and wraps: 2^ADDR_W-1 steps to 0. Return addresses wrap the same way.
- Simultaneous assertions resolve strictly by priority. For example, ret+call performs only the ret; call+branch performs only the call.
- The stack is LIFO. Count has width $clog2(RAS_DEPTH+1).
- ras_empty = (count == 0); ras_full = (count == RAS_DEPTH). Both are decoded from the registered count.

## Timing
- Every input takes effect one cycle later: control sampled at edge N is visible on pc_out after edge N.
- After rst is released with no controls asserted, pc_out sequence is RESET_VEC, RESET_VEC+1, RESET_VEC+2, … . No repeated address is permitted.
- rst asserted mid-call-chain clears the stack on that same edge. A ret on the following cycle is an underflow.
- ras_err sets on the edge that performs the offending call or ret. It clears only on rst.
- No combinational path from any input to any output.

## Configuration
- PC_RAS_EN defined: behaviour as above.
- PC_RAS_EN undefined: no stack storage is built.
  - call behaves as branch to call_addr.
  - ret is ignored; that cycle increments unless branch is asserted.
  - ras_empty is tied 1; ras_full and ras_err are tied 0.
  - Ports are identical in both builds.

## Test plan
- ADDR_W=6, RESET_VEC=5: hold rst 2 cycles, release, idle 3 cycles -> pc_out 5,6,7,8. Idle from 63 -> pc_out wraps to 0.
- pc_out=10, call call_addr=40, idle 2 cycles, ret -> pc_out 40,41,42,11; ras_empty 0 during the call, 1 after the ret.
- RAS_DEPTH=4, nested calls from pc 1,21,31,41 (call_addr 20,30,40,50), then a 5th call to 60 -> pc_out 60, ras_full 1, ras_err 1. Then 4 rets from pc 60 -> pc_out 42,32,22,2; 5th ret -> pc_out 3.
- pc_out=12, stall with call, ret and branch all asserted for 3 cycles -> pc_out stays 12, count unchanged. Drop stall with ret+call+branch all asserted (one entry holding 7) -> pc_out 7.
- Two nested calls active, assert rst -> pc_out=RESET_VEC, ras_empty 1, ras_err 0. Then ret -> pc_out RESET_VEC+1, ras_err 1.
- PC_RAS_EN undefined: pc_out=3, call to 30, then ret -> pc_out 30 then 31; ras_empty 1, ras_err 0 throughout.
